// File: rtl/bandit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bandit_arbiter
//  Purpose  : Round-robin sharing of one bandit agent among N environments;
//             a grant covers one full action->reward transaction.
//  Options  : BANDIT_ARBITER_TIMEOUT_EN - inject a -128 reward after TIMEOUT
//             cycles without one from the granted environment.
//  Revision : 1.0 - initial release
// ============================================================================
module bandit_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     greedy,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     env_action_valid,
    output logic [7:0]       env_action_data,
    input  logic [N-1:0]     env_action_ready,
    input  logic [N-1:0]     env_reward_valid,
    input  logic [8*N-1:0]   env_reward_data,
    output logic [N-1:0]     env_reward_ready,
    input  logic             agent_action_valid,
    input  logic [7:0]       agent_action_data,
    output logic             agent_action_ready,
    output logic             agent_action_gready,
    output logic             agent_reward_valid,
    output logic [7:0]       agent_reward_data,
    input  logic             agent_reward_ready
);

    localparam int         c_IDX_W  = $clog2(N);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACTION = 2'd1;
    localparam logic [1:0] c_REWARD = 2'd2;

    if (N < 2 || N > 16 || TIMEOUT < 1) begin : g_param_check
        $error("bandit_arbiter: parameter out of range");
    end

    logic [1:0]         r_state;
    logic [N-1:0]       r_grant;
    logic [c_IDX_W-1:0] r_gidx;
    logic [c_IDX_W-1:0] r_last;

    logic               w_in_action;
    logic               w_in_reward;
    logic [c_IDX_W-1:0] w_pick_idx;
    logic [c_IDX_W-1:0] w_cand;
    logic [N-1:0]       w_pick_oh;
    logic               w_env_rv;
    logic [7:0]         w_env_rd;
    logic               w_inject;
    logic               w_action_hs;
    logic               w_reward_hs;
    int                 w_j;

    // Scan from farthest to nearest so the requester closest after r_last wins.
    always_comb begin : arbitration
        w_pick_idx = r_last;
        w_cand     = r_last;
        w_pick_oh  = '0;
        w_j        = 0;
        for (int k = N; k >= 1; k--) begin
            w_j = int'(r_last) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            w_cand = c_IDX_W'(w_j);
            if (req[w_cand]) begin
                w_pick_idx = w_cand;
            end
        end
        w_pick_oh[w_pick_idx] = 1'b1;
    end

    always_comb begin : reward_mux
        w_env_rd = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_env_rd = env_reward_data[8*i +: 8];
            end
        end
    end

    assign w_in_action = (r_state == c_ACTION);
    assign w_in_reward = (r_state == c_REWARD);
    assign w_env_rv    = |(env_reward_valid & r_grant);

    assign grant               = r_grant;
    assign env_action_valid    = (w_in_action && agent_action_valid) ? r_grant : '0;
    assign env_action_data     = w_in_action ? agent_action_data : 8'h00;
    assign agent_action_ready  = w_in_action & |(env_action_ready & r_grant);
    assign agent_action_gready = (w_in_action | w_in_reward) & |(greedy & r_grant);
    assign agent_reward_valid  = w_in_reward & (w_inject | w_env_rv);
    assign agent_reward_data   = !w_in_reward ? 8'h00 : (w_inject ? 8'h80 : w_env_rd);
    assign env_reward_ready    = (w_in_reward && !w_inject && agent_reward_ready) ? r_grant : '0;

    assign w_action_hs = agent_action_valid & agent_action_ready;
    assign w_reward_hs = agent_reward_valid & agent_reward_ready;

`ifdef BANDIT_ARBITER_TIMEOUT_EN
    localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT);

    logic [c_CNT_W-1:0] r_wait;
    logic               r_inject;

    // Once injection starts it latches so a late environment reward is ignored.
    assign w_inject = w_in_reward & (r_inject | ((r_wait == c_LIMIT) & ~w_env_rv));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait   <= '0;
            r_inject <= 1'b0;
        end else if (w_in_action) begin
            r_wait   <= '0;
            r_inject <= 1'b0;
        end else if (w_in_reward && !w_reward_hs) begin
            if (r_wait != c_LIMIT) begin
                r_wait <= r_wait + 1'b1;
            end
            r_inject <= w_inject;
        end
    end
`else
    assign w_inject = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= c_IDX_W'(N - 1);
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|req) begin
                        r_grant <= w_pick_oh;
                        r_gidx  <= w_pick_idx;
                        r_state <= c_ACTION;
                    end
                end
                c_ACTION: begin
                    if (w_action_hs) begin
                        r_state <= c_REWARD;
                    end
                end
                c_REWARD: begin
                    if (w_reward_hs) begin
                        r_last  <= r_gidx;
                        r_grant <= '0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bandit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bandit_arbiter
//  Purpose  : Directed stimulus for bandit_arbiter with a cycle-level
//             transaction model and hand-computed spot checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bandit_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    logic           clock;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N-1:0]   greedy;
    logic [N-1:0]   grant;
    logic [N-1:0]   env_action_valid;
    logic [7:0]     env_action_data;
    logic [N-1:0]   env_action_ready;
    logic [N-1:0]   env_reward_valid;
    logic [8*N-1:0] env_reward_data;
    logic [N-1:0]   env_reward_ready;
    logic           agent_action_valid;
    logic [7:0]     agent_action_data;
    logic           agent_action_ready;
    logic           agent_action_gready;
    logic           agent_reward_valid;
    logic [7:0]     agent_reward_data;
    logic           agent_reward_ready;

    int n_vec  = 0;
    int n_fail = 0;

    bandit_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .req                 (req),
        .greedy              (greedy),
        .grant               (grant),
        .env_action_valid    (env_action_valid),
        .env_action_data     (env_action_data),
        .env_action_ready    (env_action_ready),
        .env_reward_valid    (env_reward_valid),
        .env_reward_data     (env_reward_data),
        .env_reward_ready    (env_reward_ready),
        .agent_action_valid  (agent_action_valid),
        .agent_action_data   (agent_action_data),
        .agent_action_ready  (agent_action_ready),
        .agent_action_gready (agent_action_gready),
        .agent_reward_valid  (agent_reward_valid),
        .agent_reward_data   (agent_reward_data),
        .agent_reward_ready  (agent_reward_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        oh2i = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) oh2i = i;
        end
    endfunction

    // Transaction-level model: phase 0 idle, 1 awaiting action, 2 awaiting reward.
    int   m_phase = 0;
    int   m_g     = 0;
    int   m_last  = N - 1;
    int   m_wait  = 0;
    bit   m_inj   = 1'b0;

    initial begin : model_compare
        logic [N-1:0] e_grant, e_eav, e_aar_vec, e_err;
        logic [7:0]   e_ead, e_ard;
        logic         e_aar, e_gr, e_arv, inj_now;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                m_phase = 0; m_g = 0; m_last = N - 1; m_wait = 0; m_inj = 1'b0;
            end
            e_grant = '0; e_eav = '0; e_err = '0; e_aar_vec = '0;
            e_ead = 8'h00; e_ard = 8'h00; e_aar = 1'b0; e_gr = 1'b0; e_arv = 1'b0;
            inj_now = 1'b0;
            if (m_phase != 0) begin
                e_grant[m_g] = 1'b1;
                e_gr = greedy[m_g];
            end
            if (m_phase == 1) begin
                e_eav[m_g] = agent_action_valid;
                e_ead = agent_action_data;
                e_aar = env_action_ready[m_g];
            end
            if (m_phase == 2) begin
`ifdef BANDIT_ARBITER_TIMEOUT_EN
                inj_now = m_inj || (m_wait >= TO && !env_reward_valid[m_g]);
`endif
                e_arv = inj_now || env_reward_valid[m_g];
                e_ard = inj_now ? 8'h80 : env_reward_data[8*m_g +: 8];
                if (!inj_now) e_err[m_g] = agent_reward_ready;
            end
            chk("grant", 32'(grant), 32'(e_grant));
            chk("env_action_valid", 32'(env_action_valid), 32'(e_eav));
            chk("env_action_data", 32'(env_action_data), 32'(e_ead));
            chk("agent_action_ready", 32'(agent_action_ready), 32'(e_aar));
            chk("agent_action_gready", 32'(agent_action_gready), 32'(e_gr));
            chk("agent_reward_valid", 32'(agent_reward_valid), 32'(e_arv));
            chk("agent_reward_data", 32'(agent_reward_data), 32'(e_ard));
            chk("env_reward_ready", 32'(env_reward_ready), 32'(e_err));
            if (reset_n) begin
                case (m_phase)
                    0: begin
                        for (int k = 1; k <= N; k++) begin
                            if (m_phase == 0 && req[(m_last + k) % N]) begin
                                m_g = (m_last + k) % N;
                                m_phase = 1;
                            end
                        end
                    end
                    1: if (agent_action_valid && env_action_ready[m_g]) begin
                        m_phase = 2; m_wait = 0; m_inj = 1'b0;
                    end
                    default: begin
                        if (e_arv && agent_reward_ready) begin
                            m_phase = 0; m_last = m_g;
                        end else begin
                            m_wait++;
                            m_inj = inj_now;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; greedy = '0; env_action_ready = '0; env_reward_valid = '0;
        env_reward_data = '0; agent_action_valid = 1'b0; agent_action_data = 8'h00;
        agent_reward_ready = 1'b0;
    endtask

    // Asserted off-edge and held across a falling edge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_grant_is(input string name, input logic [N-1:0] exp);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (grant == exp) break;
        end
        chk(name, 32'(grant), 32'(exp));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int seq[$];
        int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [N-1:0] prev;
        int gap_bad;

        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;

        // 1: single transaction through requester 0
        @(negedge clock);
        chk("t1_reset_grant", 32'(grant), 32'h0);
        chk("t1_reset_arv", 32'(agent_reward_valid), 32'h0);
        tick();
        req = 4'b0001; agent_action_valid = 1'b1; agent_action_data = 8'h2A;
        env_action_ready = 4'b0001; env_reward_valid = 4'b0001;
        env_reward_data[7:0] = 8'h10; agent_reward_ready = 1'b1;
        @(negedge clock);
        chk("t1_grant_not_yet", 32'(grant), 32'h0);
        @(negedge clock);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_env_action_data", 32'(env_action_data), 32'h2A);
        chk("t1_env_action_valid", 32'(env_action_valid), 32'h1);
        tick();
        req = '0;
        @(negedge clock);
        chk("t1_reward_valid", 32'(agent_reward_valid), 32'h1);
        chk("t1_reward_data", 32'(agent_reward_data), 32'h10);
        @(negedge clock);
        chk("t1_grant_after", 32'(grant), 32'h0);

        // 2: all requesting, strict rotation with idle gaps
        tick();
        clear_inputs();
        do_reset();
        req = 4'b1111; env_action_ready = 4'b1111; env_reward_valid = 4'b1111;
        env_reward_data = 32'h13121110; agent_action_valid = 1'b1;
        agent_action_data = 8'h33; agent_reward_ready = 1'b1;
        prev = '0;
        gap_bad = 0;
        for (int c = 0; c < 40 && seq.size() < 8; c++) begin
            @(negedge clock);
            if (grant != 0 && grant != prev) begin
                if (prev != 0) gap_bad++;
                seq.push_back(oh2i(grant));
            end
            prev = grant;
        end
        chk("t2_seq_count", 32'(seq.size()), 32'd8);
        for (int i = 0; i < 8 && i < seq.size(); i++) begin
            chk($sformatf("t2_seq[%0d]", i), 32'(seq[i]), 32'(exp_seq[i]));
        end
        chk("t2_idle_gap", 32'(gap_bad), 32'd0);

        // 3: greedy flag follows the grant
        tick();
        clear_inputs();
        do_reset();
        greedy = 4'b0100; req = 4'b0100; env_action_ready = 4'b0100;
        env_reward_valid = 4'b0100; env_reward_data[23:16] = 8'h77;
        wait_grant_is("t3_grant", 4'b0100);
        chk("t3_gready_action", 32'(agent_action_gready), 32'h1);
        tick();
        agent_action_valid = 1'b1;
        @(negedge clock);
        chk("t3_gready_action2", 32'(agent_action_gready), 32'h1);
        tick();
        agent_action_valid = 1'b0;
        @(negedge clock);
        chk("t3_gready_reward", 32'(agent_action_gready), 32'h1);
        chk("t3_reward_data", 32'(agent_reward_data), 32'h77);
        tick();
        agent_reward_ready = 1'b1;
        @(negedge clock);
        chk("t3_gready_hs", 32'(agent_action_gready), 32'h1);
        tick();
        agent_reward_ready = 1'b0; req = '0;
        @(negedge clock);
        chk("t3_gready_idle", 32'(agent_action_gready), 32'h0);

        // 4: dropped req and a stray reward from a non-granted requester
        tick();
        clear_inputs();
        do_reset();
        req = 4'b0001; agent_action_valid = 1'b1; agent_action_data = 8'h5A;
        env_action_ready = 4'b0001; env_reward_valid = 4'b0010;
        env_reward_data[15:8] = 8'h55; env_reward_data[7:0] = 8'hF0;
        agent_reward_ready = 1'b1;
        wait_grant_is("t4_grant", 4'b0001);
        tick();
        req = '0;
        @(negedge clock);
        chk("t4_stray_ignored", 32'(agent_reward_valid), 32'h0);
        chk("t4_env_reward_ready", 32'(env_reward_ready), 32'h1);
        tick();
        env_reward_valid = 4'b0011;
        @(negedge clock);
        chk("t4_reward_data", 32'(agent_reward_data), 32'hF0);
        chk("t4_env_reward_ready2", 32'(env_reward_ready), 32'h1);
        tick();
        clear_inputs();
        @(negedge clock);
        chk("t4_done", 32'(grant), 32'h0);

        // 5: asynchronous reset while requester 1 is in its reward phase
        tick();
        do_reset();
        req = 4'b0011; agent_action_valid = 1'b1; agent_action_data = 8'h11;
        env_action_ready = 4'b1111; env_reward_valid = 4'b1111;
        env_reward_data = 32'h44332211; agent_reward_ready = 1'b1;
        wait_grant_is("t5_first", 4'b0001);
        wait_grant_is("t5_second", 4'b0010);
        tick();
        agent_reward_ready = 1'b0;
        @(negedge clock);
        chk("t5_in_reward", 32'(agent_reward_valid), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(grant), 32'h0);
        chk("t5_rst_arv", 32'(agent_reward_valid), 32'h0);
        chk("t5_rst_err", 32'(env_reward_ready), 32'h0);
        chk("t5_rst_gready", 32'(agent_action_gready), 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        agent_reward_ready = 1'b1;
        wait_grant_is("t5_after_reset", 4'b0001);

        // 6: environment never rewards
        tick();
        clear_inputs();
        do_reset();
        req = 4'b0001; agent_action_valid = 1'b1; env_action_ready = 4'b0001;
        wait_grant_is("t6_grant", 4'b0001);
        tick();
        req = '0; agent_action_valid = 1'b0;
        for (int c = 0; c < TO; c++) begin
            @(negedge clock);
            chk($sformatf("t6_wait%0d", c), 32'(agent_reward_valid), 32'h0);
        end
`ifdef BANDIT_ARBITER_TIMEOUT_EN
        @(negedge clock);
        chk("t6_inject_valid", 32'(agent_reward_valid), 32'h1);
        chk("t6_inject_data", 32'(agent_reward_data), 32'h80);
        tick();
        env_reward_valid = 4'b0001; env_reward_data[7:0] = 8'h22;
        @(negedge clock);
        chk("t6_late_data", 32'(agent_reward_data), 32'h80);
        chk("t6_late_err", 32'(env_reward_ready), 32'h0);
        tick();
        agent_reward_ready = 1'b1;
        @(negedge clock);
        chk("t6_hs_valid", 32'(agent_reward_valid), 32'h1);
        tick();
        clear_inputs();
        @(negedge clock);
        chk("t6_idle", 32'(grant), 32'h0);
`else
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            chk("t6_still_waiting", 32'(agent_reward_valid), 32'h0);
        end
        chk("t6_grant_held", 32'(grant), 32'h1);
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
